pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. Drives the bubble input of the ID/EX register, the write enables of the PC and IF/ID, and freeze enables for ID/EX and EX/MEM.
- Detects load-use hazards against the instruction in EX.
- Freezes the pipeline while a multi-cycle data-memory access waits for its ready handshake.
- Flushes IF/ID on taken branches.
- Keeps saturating performance counters and a sticky memory-timeout error.

Parameters:
- MEM_TIMEOUT, 64: maximum cycles spent in MEM_WAIT before entering ERROR. Legal range 2..255.
- STALL_CNT_W, 16: width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- id_rs_a  in  5  Rs address of instruction in ID
- id_rt_a  in  5  Rt address of instruction in ID
- id_uses_rt  in  1  ID instruction reads Rt as a source
- ex_rt_a  in  5  Rt_a_out of ID/EX
- ex_mem_to_reg  in  1  MemToReg_out of ID/EX (load in EX)
- branch_taken  in  1  branch resolved taken in ID
- mem_req  in  1  MEM stage has an active load/store
- mem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID write enable
- ifid_flush  out  1  zero IF/ID on next edge
- idex_bubble  out  1  to ID/EX bubble
- idex_hold  out  1  ID/EX freeze enable
- exmem_hold  out  1  EX/MEM freeze enable
- mem_error  out  1  sticky timeout flag
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with pc_write=0
- flush_count  out  8  saturating count of ifid_flush cycles

Behaviour:
- State machine with states RUN, MEM_WAIT and ERROR. Registers: state, wait_cnt[7:0], mem_error, stall_cycles, flush_count.
- Control outputs are Mealy (combinational from state and inputs), so they take effect in the same cycle as the hazard. Latency is 0.
- Reset (async, active-high): state=RUN, wait_cnt=0, mem_error=0, both counters=0.
- While reset is high, outputs are pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, idex_hold=0, exmem_hold=0.
- load_use = ex_mem_to_reg & (ex_rt_a != 0) & ((ex_rt_a == id_rs_a) | (id_uses_rt & (ex_rt_a == id_rt_a))).
- mem_stall = mem_req & ~mem_ready.
- RUN, priority order:
  1. mem_stall: freeze. pc_write=0, ifid_write=0, idex_hold=1, exmem_hold=1, idex_bubble=0, ifid_flush=0. Next state MEM_WAIT, wait_cnt<=1.
  2. load_use: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0. A coincident branch_taken is suppressed; it is re-evaluated next cycle.
  3. branch_taken: ifid_flush=1, pc_write=1, ifid_write=1.
  4. Otherwise: pc_write=1, ifid_write=1, all other outputs 0.
- MEM_WAIT:
  - mem_ready=1: outputs as RUN with mem_stall=0 (pipeline advances this cycle), next state RUN.
  - Else if wait_cnt == MEM_TIMEOUT-1: freeze, next state ERROR, mem_error<=1.
  - Else: freeze, wait_cnt<=wait_cnt+1.
- ERROR: permanent freeze; all inputs ignored; leaves only via reset. mem_error stays 1.
- Freeze always takes precedence over bubble: idex_bubble and idex_hold are never 1 simultaneously.
- stall_cycles: increments every non-reset cycle with pc_write=0 and saturates at all-ones.
- flush_count: increments when ifid_flush=1 and saturates at 255.
- A mem_req/mem_ready pair arriving in the same RUN cycle causes no stall.
- Reset asserted mid-MEM_WAIT aborts the wait immediately; the asynchronous clear applies.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - state encoding: RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2
  - REG_ZERO=5'd0
- The pure combinational load-use comparator is a natural sub-module, load_use_detect, reused by the forwarding unit's tests.

Test Plan:
- Load-use: ex_mem_to_reg=1, ex_rt_a=5, id_rs_a=5 -> same cycle pc_write=0, ifid_write=0, idex_bubble=1. Repeat with ex_rt_a=0 -> no stall.
- Branch during load-use: load_use plus branch_taken=1 -> ifid_flush=0. Next cycle, with the hazard cleared -> ifid_flush=1, flush_count=1.
- Memory wait: mem_req=1 with mem_ready=0 for 3 cycles, then 1 -> idex_hold=exmem_hold=1 for 3 cycles, release on the ready cycle, state back to RUN, stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_error=1 after 4 freeze cycles. The freeze persists with mem_ready later 1 until reset.
- Simultaneous mem_stall and load_use -> idex_hold=1, idex_bubble=0. After mem_ready -> a bubble is inserted the next cycle if the hazard persists.
- Async reset pulse mid-MEM_WAIT (between clock edges) -> state RUN, counters 0, idex_bubble=1 while reset is high, normal flow after deassertion.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl_pkg
//  Description : Shared state encoding and constants for the pipeline hazard
//                control logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    // Sequencer states for the stall/flush controller
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hazard_state_t;

    // Register 0 is hard-wired to zero and never creates a dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module      : load_use_detect
//  Description : Pure combinational load-use comparator. Flags when the load
//                in EX writes a register that the instruction in ID reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       ex_mem_to_reg,
    input  logic [4:0] ex_rt_a,
    input  logic [4:0] id_rs_a,
    input  logic [4:0] id_rt_a,
    input  logic       id_uses_rt,
    output logic       load_use
);

    logic w_rs_match;
    logic w_rt_match;

    // Rt only counts as a source when the ID instruction actually reads it
    always_comb begin
        w_rs_match = (ex_rt_a == id_rs_a);
        w_rt_match = id_uses_rt & (ex_rt_a == id_rt_a);
        load_use   = ex_mem_to_reg & (ex_rt_a != REG_ZERO) & (w_rs_match | w_rt_match);
    end

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Central stall/flush sequencer for the 5-stage pipeline.
//                Mealy control outputs for load-use bubbles, memory-wait
//                freezes and branch flushes, plus saturating performance
//                counters and a sticky memory-timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             id_rs_a,
    input  logic [4:0]             id_rt_a,
    input  logic                   id_uses_rt,
    input  logic [4:0]             ex_rt_a,
    input  logic                   ex_mem_to_reg,
    input  logic                   branch_taken,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   idex_bubble,
    output logic                   idex_hold,
    output logic                   exmem_hold,
    output logic                   mem_error,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [7:0]             flush_count
);

    // Last wait_cnt value tolerated before the access is declared dead
    localparam logic [7:0] c_timeout_last = 8'(MEM_TIMEOUT - 1);

    hazard_state_t          r_state;
    hazard_state_t          w_state_nxt;
    logic [7:0]             r_wait_cnt;
    logic [7:0]             w_wait_cnt_nxt;
    logic                   r_mem_error;
    logic                   w_set_error;
    logic [STALL_CNT_W-1:0] r_stall_cycles;
    logic [7:0]             r_flush_count;

    logic w_load_use;
    logic w_mem_stall;
    logic w_freeze;
    logic w_advance;

    logic w_pc_write;
    logic w_ifid_write;
    logic w_ifid_flush;
    logic w_idex_bubble;
    logic w_idex_hold;
    logic w_exmem_hold;

    load_use_detect u_load_use_detect (
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_rt_a       (ex_rt_a),
        .id_rs_a       (id_rs_a),
        .id_rt_a       (id_rt_a),
        .id_uses_rt    (id_uses_rt),
        .load_use      (w_load_use)
    );

    assign w_mem_stall = mem_req & ~mem_ready;

    // State register, wait counter, sticky error and performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= RUN;
            r_wait_cnt     <= 8'd0;
            r_mem_error    <= 1'b0;
            r_stall_cycles <= '0;
            r_flush_count  <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_mem_error <= r_mem_error | w_set_error;
            if (!w_pc_write && (r_stall_cycles != {STALL_CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_ifid_flush && (r_flush_count != 8'hFF)) begin
                r_flush_count <= r_flush_count + 8'd1;
            end
        end
    end

    // Next state: decide whether the pipeline freezes or advances this cycle
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_set_error    = 1'b0;
        w_freeze       = 1'b0;
        w_advance      = 1'b0;
        case (r_state)
            RUN: begin
                if (w_mem_stall) begin
                    w_freeze       = 1'b1;
                    w_state_nxt    = MEM_WAIT;
                    w_wait_cnt_nxt = 8'd1;
                end else begin
                    w_advance = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    // Access completes: the pipeline moves on in this same cycle
                    w_advance      = 1'b1;
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = 8'd0;
                end else if (r_wait_cnt == c_timeout_last) begin
                    w_freeze    = 1'b1;
                    w_state_nxt = ERROR;
                    w_set_error = 1'b1;
                end else begin
                    w_freeze       = 1'b1;
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            ERROR: begin
                w_freeze = 1'b1;
            end
            default: begin
                // Unreachable encoding: treat as a fatal memory condition
                w_freeze    = 1'b1;
                w_state_nxt = ERROR;
                w_set_error = 1'b1;
            end
        endcase
    end

    // Mealy control outputs; freeze outranks bubble, bubble outranks flush
    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_idex_hold   = 1'b0;
        w_exmem_hold  = 1'b0;
        if (w_freeze) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_idex_hold  = 1'b1;
            w_exmem_hold = 1'b1;
        end else if (w_advance && w_load_use) begin
            // A coincident taken branch is dropped here and resolves again next cycle
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
        end else if (w_advance && branch_taken) begin
            w_ifid_flush = 1'b1;
        end
    end

    // Reset forces a bubble into ID/EX and stops instruction fetch
    always_comb begin
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
            idex_hold   = 1'b0;
            exmem_hold  = 1'b0;
        end else begin
            pc_write    = w_pc_write;
            ifid_write  = w_ifid_write;
            ifid_flush  = w_ifid_flush;
            idex_bubble = w_idex_bubble;
            idex_hold   = w_idex_hold;
            exmem_hold  = w_exmem_hold;
        end
    end

    assign mem_error    = r_mem_error;
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule : pipeline_hazard_ctrl
`default_nettype wire
